axil_sram_slave: RTL and testbench
==================================

Name: axil_sram_slave

Overview:
- AXI4-Lite responder that terminates the bus from the CPU-side AXI-Lite master and backs it with an on-chip word-addressed SRAM.
- Supports byte strobes and independent AW/W arrival, and returns OKAY or DECERR responses.
- Read and write channels run concurrently; each channel has one outstanding transaction.
- Serves as the memory endpoint for the CPU AXI-Lite path.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width (32 only); strobe width is DATA_W/8.
- DEPTH_WORDS, 1024, SRAM depth in words (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0; decoded window is BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- AWADDR  in  ADDR_W  write address
- AWPROT  in  3  ignored
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_W  write data
- WSTRB  in  DATA_W/8  byte enables
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  ADDR_W  read address
- ARPROT  in  3  ignored
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_W  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready

Behaviour:
- Reset values (async assert, sync release):
  - BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0.
  - aw_held=0, w_held=0, write FSM=W_IDLE, read FSM=R_IDLE.
  - AWREADY=1, WREADY=1, ARREADY=1 once state is idle.
  - SRAM contents are not reset.
- Write FSM states: W_IDLE, W_RESP.
  - AWREADY = W_IDLE & !aw_held.
  - WREADY = W_IDLE & !w_held.
  - AW handshake captures AWADDR and sets aw_held. W handshake captures WDATA/WSTRB and sets w_held. Both may occur in the same cycle, in either order, any number of cycles apart.
  - Commit occurs in the first cycle where both are available, using the held value or the value arriving that cycle. At that clock edge:
    - If in window: bytes with WSTRB[i]=1 are written and BRESP=OKAY.
    - Otherwise: no write and BRESP=DECERR (2'b11).
    - BVALID=1, holds clear, state goes to W_RESP.
  - Fastest path: AW and W in the same cycle give BVALID on the next cycle.
  - W_RESP: BVALID stays 1 and BRESP is stable until BREADY, then W_IDLE. The earliest next AW/W acceptance is the cycle after the B handshake.
  - WSTRB=0 commits nothing and returns OKAY.
- Read FSM states: R_IDLE, R_DATA.
  - ARREADY = R_IDLE.
  - On AR handshake, the SRAM word is read at that edge. Next cycle: RVALID=1, with RDATA = word and RRESP=OKAY, or RDATA=0 and RRESP=DECERR if out of window. State goes to R_DATA.
  - Latency is 1 cycle from AR handshake to RVALID.
  - R_DATA: RVALID, RDATA and RRESP are held stable until RREADY, then R_IDLE.
- Addressing:
  - Word index = (addr-BASE_ADDR)>>2. Addr[1:0] are ignored (no misalignment error).
  - The window check uses the full ADDR_W bits.
- Same-cycle write commit and AR handshake to the same word: read returns the old data. The write is visible to subsequent reads.
- VALID inputs dropping without a handshake are legal and are ignored.
- rst mid-transaction: pending holds and responses are discarded and no commit occurs. An SRAM write is never partially applied: the write enable is sampled only at a non-reset edge.

Decomposition:
- Package axil_pkg:
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Write-state enum (W_IDLE, W_RESP) and read-state enum (R_IDLE, R_DATA).
  - An in_window() function.
- Sub-module axil_sram_bank: DEPTH_WORDS x DATA_W, one byte-enabled synchronous write port, one synchronous read port, read-before-write.

Test Plan:
- AW+W same cycle: addr 0x8000_0010, data 0xDEADBEEF, strb 4'hF -> BVALID next cycle, BRESP=00; then AR 0x8000_0010 -> RVALID 1 cycle later, RDATA=0xDEADBEEF, RRESP=00.
- W three cycles before AW: data 0x11223344, strb 4'b0101 to a word holding 0xDEADBEEF -> WREADY low after capture until B handshake; readback 0xDE22BE44.
- Out of window: write 0x7FFF_FFFC -> BRESP=11 and memory unchanged; read 0x8000_1000 with DEPTH 1024 -> RRESP=11, RDATA=0.
- Backpressure: BREADY and RREADY held low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stable; AWREADY/WREADY/ARREADY stay 0 until each handshake.
- Collision: write commit and AR to the same word in the same cycle, old 0xAAAA_AAAA, new 0x5555_5555 -> RDATA=0xAAAA_AAAA; next read -> 0x5555_5555.
- Reset with aw_held=1 and RVALID=1 -> all VALIDs 0 immediately, READYs 1 after release, and no write occurred.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes, channel FSM state types and address decode helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // Evaluated at 64 bits so that base + span cannot wrap for any
    // address width below 64; the caller zero-extends its operands.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] span);
        return (addr >= base) && (addr < (base + span));
    endfunction

endpackage

// File: rtl/axil_sram_bank.sv
// Word-addressed SRAM: one byte-enabled synchronous write port, one synchronous read port.
// Latency: read data valid the cycle after re; a same-edge write to the read word returns the old word.
// Backpressure: none; rdata holds its value until the next re.
// Ports: clk, rst (clears only the read register), we/waddr/wstrb/wdata, re/raddr/rdata.
module axil_sram_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Non-blocking read of the pre-edge array gives read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite responder backed by an on-chip SRAM; byte strobes, independent AW/W, OKAY/DECERR.
// Latency: AW+W same cycle -> BVALID next cycle; AR -> RVALID next cycle; one outstanding per channel.
// Backpressure: B/R held stable until BREADY/RREADY; AW/W/AR not accepted while a response is pending.
// Ports: clk, rst, AXI4-Lite AW/W/B/AR/R channels (AWPROT/ARPROT are ignored).
module axil_sram_slave
    import axil_pkg::*;
#(
    parameter int               ADDR_W      = 32,
    parameter int               DATA_W      = 32,
    parameter int               DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [2:0]          AWPROT,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [2:0]          ARPROT,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam int          STRB_W    = DATA_W / 8;
    localparam logic [63:0] WIN_BYTES = 64'(DEPTH_WORDS) * 64'd4;

    // ---------------- write channel ----------------
    wstate_t             wstate, wstate_nxt;
    logic                aw_held, w_held;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [1:0]          bresp_q;

    logic                aw_fire, w_fire, commit;
    logic [ADDR_W-1:0]   w_addr, w_off;
    logic [DATA_W-1:0]   w_data;
    logic [STRB_W-1:0]   w_strb;
    logic                w_inwin, mem_we;

    assign AWREADY = (wstate == W_IDLE) && !aw_held;
    assign WREADY  = (wstate == W_IDLE) && !w_held;
    assign aw_fire = AWVALID && AWREADY;
    assign w_fire  = WVALID && WREADY;

    // Commit as soon as both halves exist, taking whichever is held or
    // arriving right now.
    assign commit = (wstate == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
    assign w_addr = aw_held ? awaddr_q : AWADDR;
    assign w_data = w_held  ? wdata_q  : WDATA;
    assign w_strb = w_held  ? wstrb_q  : WSTRB;
    assign w_off  = w_addr - BASE_ADDR;
    assign w_inwin = in_window(64'(w_addr), 64'(BASE_ADDR), WIN_BYTES);
    // Gating with rst keeps an edge under reset from touching the array.
    assign mem_we = commit && w_inwin && !rst;

    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE:  if (commit) wstate_nxt = W_RESP;
            W_RESP:  if (BREADY) wstate_nxt = W_IDLE;
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wstate_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= w_inwin ? RESP_OKAY : RESP_DECERR;
        end else begin
            if (aw_fire) begin
                aw_held  <= 1'b1;
                awaddr_q <= AWADDR;
            end
            if (w_fire) begin
                w_held  <= 1'b1;
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
        end
    end

    assign BVALID = (wstate == W_RESP);
    assign BRESP  = bresp_q;

    // ---------------- read channel ----------------
    rstate_t             rstate, rstate_nxt;
    logic                ar_fire, r_inwin, r_err, mem_re;
    logic [ADDR_W-1:0]   r_off;
    logic [DATA_W-1:0]   bank_rdata;

    assign ARREADY = (rstate == R_IDLE);
    assign ar_fire = ARVALID && ARREADY;
    assign r_off   = ARADDR - BASE_ADDR;
    assign r_inwin = in_window(64'(ARADDR), 64'(BASE_ADDR), WIN_BYTES);
    assign mem_re  = ar_fire && r_inwin && !rst;

    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_IDLE:  if (ar_fire) rstate_nxt = R_DATA;
            R_DATA:  if (RREADY)  rstate_nxt = R_IDLE;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate <= R_IDLE;
            r_err  <= 1'b0;
        end else begin
            rstate <= rstate_nxt;
            if (ar_fire) r_err <= !r_inwin;
        end
    end

    assign RVALID = (rstate == R_DATA);
    assign RRESP  = r_err ? RESP_DECERR : RESP_OKAY;
    // Bank output only changes on an in-window AR, so RDATA stays stable
    // for the whole R_DATA phase.
    assign RDATA  = r_err ? '0 : bank_rdata;

    axil_sram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (w_off[IDX_W+1:2]),
        .wstrb (w_strb),
        .wdata (w_data),
        .re    (mem_re),
        .raddr (r_off[IDX_W+1:2]),
        .rdata (bank_rdata)
    );

    // Protection bits and the byte-lane/high offset bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, w_off, r_off};

endmodule

// File: tb/tb_axil_sram_slave.sv
module tb_axil_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = '0;
    logic [2:0]  ARPROT = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axil_sram_slave #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h8000_0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .AWADDR  (AWADDR),
        .AWPROT  (AWPROT),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARPROT  (ARPROT),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic b_accept();
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic rd_issue(input logic [31:0] a);
        ARADDR = a; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic r_accept();
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (BVALID !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid: got %b want 0", BVALID); end
        n_chk++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", RVALID); end
        n_chk++; if (BRESP !== 2'b00) begin n_fail++; $display("FAIL rst_bresp: got %b want 00", BRESP); end
        n_chk++; if (RRESP !== 2'b00) begin n_fail++; $display("FAIL rst_rresp: got %b want 00", RRESP); end
        n_chk++; if (RDATA !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", RDATA); end
        tick(); tick();
        rst = 1'b0;
        tick();
        n_chk++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin n_fail++; $display("FAIL rst_readys: got %b want 111", {AWREADY, WREADY, ARREADY}); end
    endtask

    task automatic test_aw_w_same();
        wr_issue(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        n_chk++; if (BVALID !== 1'b1) begin n_fail++; $display("FAIL same_bvalid: got %b want 1", BVALID); end
        n_chk++; if (BRESP !== 2'b00) begin n_fail++; $display("FAIL same_bresp: got %b want 00", BRESP); end
        b_accept();
        n_chk++; if (BVALID !== 1'b0) begin n_fail++; $display("FAIL same_bvalid_clr: got %b want 0", BVALID); end
        rd_issue(32'h8000_0010);
        n_chk++; if (RVALID !== 1'b1) begin n_fail++; $display("FAIL same_rvalid: got %b want 1", RVALID); end
        n_chk++; if (RDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL same_rdata: got %h want deadbeef", RDATA); end
        n_chk++; if (RRESP !== 2'b00) begin n_fail++; $display("FAIL same_rresp: got %b want 00", RRESP); end
        r_accept();
        n_chk++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL same_rvalid_clr: got %b want 0", RVALID); end
    endtask

    task automatic test_w_before_aw();
        WDATA = 32'h1122_3344; WSTRB = 4'b0101; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        n_chk++; if (WREADY !== 1'b0) begin n_fail++; $display("FAIL wfirst_wready: got %b want 0", WREADY); end
        n_chk++; if (AWREADY !== 1'b1) begin n_fail++; $display("FAIL wfirst_awready: got %b want 1", AWREADY); end
        n_chk++; if (BVALID !== 1'b0) begin n_fail++; $display("FAIL wfirst_early_b: got %b want 0", BVALID); end
        tick(); tick();
        n_chk++; if (WREADY !== 1'b0) begin n_fail++; $display("FAIL wfirst_wready_hold: got %b want 0", WREADY); end
        AWADDR = 32'h8000_0010; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        n_chk++; if (BVALID !== 1'b1) begin n_fail++; $display("FAIL wfirst_bvalid: got %b want 1", BVALID); end
        n_chk++; if (BRESP !== 2'b00) begin n_fail++; $display("FAIL wfirst_bresp: got %b want 00", BRESP); end
        n_chk++; if (WREADY !== 1'b0) begin n_fail++; $display("FAIL wfirst_wready_resp: got %b want 0", WREADY); end
        b_accept();
        n_chk++; if (WREADY !== 1'b1) begin n_fail++; $display("FAIL wfirst_wready_back: got %b want 1", WREADY); end
        rd_issue(32'h8000_0010);
        n_chk++; if (RDATA !== 32'hDE22_BE44) begin n_fail++; $display("FAIL wfirst_rdata: got %h want de22be44", RDATA); end
        r_accept();
    endtask

    task automatic test_out_of_window();
        // Seed the words a broken decode would alias onto.
        wr_issue(32'h8000_0FFC, 32'hCAFE_F00D, 4'hF); b_accept();
        wr_issue(32'h8000_0000, 32'h0BAD_F00D, 4'hF); b_accept();
        wr_issue(32'h7FFF_FFFC, 32'h1234_5678, 4'hF);
        n_chk++; if (BRESP !== 2'b11) begin n_fail++; $display("FAIL oow_bresp: got %b want 11", BRESP); end
        b_accept();
        rd_issue(32'h8000_0FFC);
        n_chk++; if (RDATA !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL oow_mem_unchanged: got %h want cafef00d", RDATA); end
        n_chk++; if (RRESP !== 2'b00) begin n_fail++; $display("FAIL oow_last_word_rresp: got %b want 00", RRESP); end
        r_accept();
        rd_issue(32'h8000_1000);
        n_chk++; if (RRESP !== 2'b11) begin n_fail++; $display("FAIL oow_rresp: got %b want 11", RRESP); end
        n_chk++; if (RDATA !== 32'h0) begin n_fail++; $display("FAIL oow_rdata: got %h want 0", RDATA); end
        r_accept();
    endtask

    task automatic test_backpressure();
        AWADDR = 32'h8000_0020; WDATA = 32'h0F0F_0F0F; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h8000_0010; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_chk++; if (BVALID !== 1'b1) begin n_fail++; $display("FAIL bp_bvalid[%0d]: got %b want 1", c, BVALID); end
            n_chk++; if (BRESP !== 2'b00) begin n_fail++; $display("FAIL bp_bresp[%0d]: got %b want 00", c, BRESP); end
            n_chk++; if ({AWREADY, WREADY} !== 2'b00) begin n_fail++; $display("FAIL bp_wreadys[%0d]: got %b want 00", c, {AWREADY, WREADY}); end
            n_chk++; if (RVALID !== 1'b1) begin n_fail++; $display("FAIL bp_rvalid[%0d]: got %b want 1", c, RVALID); end
            n_chk++; if (RDATA !== 32'hDE22_BE44) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h want de22be44", c, RDATA); end
            n_chk++; if (RRESP !== 2'b00) begin n_fail++; $display("FAIL bp_rresp[%0d]: got %b want 00", c, RRESP); end
            n_chk++; if (ARREADY !== 1'b0) begin n_fail++; $display("FAIL bp_arready[%0d]: got %b want 0", c, ARREADY); end
            tick();
        end
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        n_chk++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin n_fail++; $display("FAIL bp_readys_back: got %b want 111", {AWREADY, WREADY, ARREADY}); end
        n_chk++; if ({BVALID, RVALID} !== 2'b00) begin n_fail++; $display("FAIL bp_valids_clr: got %b want 00", {BVALID, RVALID}); end
        rd_issue(32'h8000_0020);
        n_chk++; if (RDATA !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL bp_write_landed: got %h want 0f0f0f0f", RDATA); end
        r_accept();
    endtask

    task automatic test_collision();
        wr_issue(32'h8000_0030, 32'hAAAA_AAAA, 4'hF); b_accept();
        AWADDR = 32'h8000_0030; WDATA = 32'h5555_5555; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h8000_0030; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        n_chk++; if (RDATA !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL coll_old: got %h want aaaaaaaa", RDATA); end
        n_chk++; if (BVALID !== 1'b1) begin n_fail++; $display("FAIL coll_bvalid: got %b want 1", BVALID); end
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        rd_issue(32'h8000_0030);
        n_chk++; if (RDATA !== 32'h5555_5555) begin n_fail++; $display("FAIL coll_new: got %h want 55555555", RDATA); end
        r_accept();
    endtask

    task automatic test_reset_mid();
        wr_issue(32'h8000_0040, 32'h0102_0304, 4'hF); b_accept();
        AWADDR = 32'h8000_0040; AWVALID = 1'b1;
        ARADDR = 32'h8000_0040; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        n_chk++; if (AWREADY !== 1'b0) begin n_fail++; $display("FAIL mid_aw_held: got %b want 0", AWREADY); end
        n_chk++; if (RVALID !== 1'b1) begin n_fail++; $display("FAIL mid_rvalid_pre: got %b want 1", RVALID); end
        // A leftover hold would commit this data if reset failed to clear it.
        WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF; WVALID = 1'b1;
        rst = 1'b1;
        #1;
        n_chk++; if ({BVALID, RVALID} !== 2'b00) begin n_fail++; $display("FAIL mid_valids_async: got %b want 00", {BVALID, RVALID}); end
        tick(); tick();
        WVALID = 1'b0;
        rst = 1'b0;
        tick();
        n_chk++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin n_fail++; $display("FAIL mid_readys: got %b want 111", {AWREADY, WREADY, ARREADY}); end
        n_chk++; if (BVALID !== 1'b0) begin n_fail++; $display("FAIL mid_no_bvalid: got %b want 0", BVALID); end
        rd_issue(32'h8000_0040);
        n_chk++; if (RDATA !== 32'h0102_0304) begin n_fail++; $display("FAIL mid_no_write: got %h want 01020304", RDATA); end
        r_accept();
    endtask

    initial begin
        test_reset();
        test_aw_w_same();
        test_w_before_aw();
        test_out_of_window();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
